// File: rtl/if_pkg.sv
// if_pkg: shared FSM state encoding, array sizing helpers and saturating add for the time-multiplexed IF network
package if_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, UPDATE, DONE} state_t;
  function automatic int max_n(input int a, input int b, input int c);
    return a > b ? (a > c ? a : c) : (b > c ? b : c);
  endfunction
  function automatic int addr_w(input int l, input int m);
    return $clog2(l * m * m);
  endfunction
  function automatic longint sat_add(input longint a, input longint b, input int w);
    longint hi, s;
    hi = (longint'(1) <<< (w - 1)) - 1;
    s = a + b;
    return s > hi ? hi : (s < -hi - 1 ? -hi - 1 : s);
  endfunction
endpackage

// File: rtl/if_neuron_update.sv
// if_neuron_update: combinational IF neuron step; in v_in/rf_in/acc -> out v_out/rf_out/spike (saturating integrate, threshold, refractory)
module if_neuron_update
  import if_pkg::*;
#(
  parameter int POT_SIZE = 16,
  parameter int THRESH = 15,
  parameter int RESET = 0,
  parameter int REFRAC = 5,
  parameter int RW = 3
) (
  input  logic signed [POT_SIZE-1:0] v_in,
  input  logic        [RW-1:0]       rf_in,
  input  logic signed [POT_SIZE-1:0] acc,
  output logic signed [POT_SIZE-1:0] v_out,
  output logic        [RW-1:0]       rf_out,
  output logic                       spike
);
  logic signed [POT_SIZE-1:0] v_sum;
  logic refr;
  always_comb begin
    v_sum = POT_SIZE'(sat_add(longint'(v_in), longint'(acc), POT_SIZE));
    refr = rf_in != '0;
    spike = !refr && v_sum >= POT_SIZE'(THRESH);
    v_out = refr ? v_in : (spike ? POT_SIZE'(RESET) : v_sum);
    rf_out = refr ? rf_in - RW'(1) : (spike ? RW'(REFRAC) : '0);
  end
endmodule

// File: rtl/if_tmux_network.sv
// if_tmux_network: shared-datapath IF network; start/spike_in/clear_state/wt_* in, busy/done/spike_out out, async active-low rst
module if_tmux_network
  import if_pkg::*;
#(
  parameter int THRESH = 15,
  parameter int RESET = 0,
  parameter int REFRAC = 5,
  parameter int WEIGHT_SIZE = 8,
  parameter int POT_SIZE = 16,
  parameter int NUM_INPUTS = 4,
  parameter int NUM_OUTPUTS = 1,
  parameter int NUM_LAYERS = 1,
  parameter int NUM_HIDDEN_LAYER_NEURONS = 4,
  localparam int L = NUM_LAYERS + 2,
  localparam int MAXN = max_n(NUM_INPUTS, NUM_HIDDEN_LAYER_NEURONS, NUM_OUTPUTS),
  localparam int AW = addr_w(L, MAXN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NUM_INPUTS-1:0]         spike_in,
  input  logic                          clear_state,
  input  logic                          wt_we,
  input  logic [AW-1:0]                 wt_addr,
  input  logic signed [WEIGHT_SIZE-1:0] wt_data,
  output logic                          busy,
  output logic                          done,
  output logic [NUM_OUTPUTS-1:0]        spike_out
);
  localparam int NWT = L * MAXN * MAXN;
  localparam int NNU = L * MAXN;
  localparam int NW = MAXN > 1 ? $clog2(MAXN) : 1;
  localparam int LW = $clog2(L);
  localparam int NIW = $clog2(NNU);
  localparam int RW = $clog2(REFRAC + 2);
  state_t state, nxt;
  logic [LW-1:0] layer;
  logic [NW-1:0] post, pre;
  logic signed [POT_SIZE-1:0] acc;
  logic [MAXN-1:0] pre_sp, cur_sp, sp_nxt;
  logic signed [WEIGHT_SIZE-1:0] w [NWT];
  logic signed [POT_SIZE-1:0] v [NNU];
  logic [RW-1:0] rf [NNU];
  logic [AW-1:0] widx;
  logic [NIW-1:0] nidx;
  logic last_pre, last_post, last_layer, idle_ok, accept;
  logic signed [POT_SIZE-1:0] nu_v;
  logic [RW-1:0] nu_rf;
  logic nu_spike;
  always_comb begin
    last_layer = layer == LW'(L - 1);
    last_pre = pre == (layer == '0 ? NW'(NUM_INPUTS - 1) : NW'(NUM_HIDDEN_LAYER_NEURONS - 1));
    last_post = post == (last_layer ? NW'(NUM_OUTPUTS - 1) : NW'(NUM_HIDDEN_LAYER_NEURONS - 1));
    idle_ok = state == IDLE || state == DONE;
    accept = state == IDLE && start && !clear_state;
    widx = AW'((int'(layer) * MAXN + int'(post)) * MAXN + int'(pre));
    nidx = NIW'(int'(layer) * MAXN + int'(post));
    sp_nxt = cur_sp | (MAXN'(nu_spike) << post);
    busy = !idle_ok;
    done = state == DONE;
    nxt = state == IDLE   ? (accept ? ACCUM : IDLE) :
          state == ACCUM  ? (last_pre ? UPDATE : ACCUM) :
          state == UPDATE ? (last_post && last_layer ? DONE : ACCUM) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      layer <= '0;
      post <= '0;
      pre <= '0;
      acc <= '0;
      pre_sp <= '0;
      cur_sp <= '0;
      spike_out <= '0;
      for (int i = 0; i < NWT; i++) w[i] <= '0;
      for (int i = 0; i < NNU; i++) begin
        v[i] <= '0;
        rf[i] <= '0;
      end
    end else begin
      if (idle_ok && wt_we && int'(wt_addr) < NWT) w[wt_addr] <= wt_data;
      if (idle_ok && clear_state)
        for (int i = 0; i < NNU; i++) begin
          v[i] <= '0;
          rf[i] <= '0;
        end
      if (accept) begin
        layer <= '0;
        post <= '0;
        pre <= '0;
        acc <= '0;
        cur_sp <= '0;
        pre_sp <= MAXN'(spike_in);
      end
      if (state == ACCUM) begin
        acc <= pre_sp[pre] ? POT_SIZE'(sat_add(longint'(acc), longint'(w[widx]), POT_SIZE)) : acc;
        pre <= last_pre ? '0 : pre + NW'(1);
      end
      if (state == UPDATE) begin
        v[nidx] <= nu_v;
        rf[nidx] <= nu_rf;
        acc <= '0;
        cur_sp <= last_post ? '0 : sp_nxt;
        pre_sp <= last_post ? sp_nxt : pre_sp;
        post <= last_post ? '0 : post + NW'(1);
        layer <= !last_post ? layer : (last_layer ? '0 : layer + LW'(1));
        if (last_post && last_layer) spike_out <= sp_nxt[NUM_OUTPUTS-1:0];
      end
    end
  end
  if_neuron_update #(
    .POT_SIZE(POT_SIZE),
    .THRESH(THRESH),
    .RESET(RESET),
    .REFRAC(REFRAC),
    .RW(RW)
  ) u_nu (
    .v_in(v[nidx]),
    .rf_in(rf[nidx]),
    .acc(acc),
    .v_out(nu_v),
    .rf_out(nu_rf),
    .spike(nu_spike)
  );
endmodule

// File: tb/tb_if_tmux_network.sv
// tb_if_tmux_network: scoreboard bench for two network instances (default and 8-bit potentials)
module tb_if_tmux_network;
  logic clk = 0;
  logic rst;
  logic start0, start1, clr0, clr1, we0, we1;
  logic [3:0] sin0, sin1;
  logic [5:0] addr0, addr1;
  logic [7:0] wd0, wd1;
  logic busy0, busy1, done0, done1;
  logic [0:0] so0, so1;
  int n_tests = 0, n_fail = 0, nd0 = 0, nd1 = 0;
  logic q0[$];
  logic q1[$];
  int mw[2][3][4][4];
  int mv[2][3][4];
  int mr[2][3][4];
  always #5 clk = ~clk;
  if_tmux_network u_d0 (
    .clk(clk), .rst(rst), .start(start0), .spike_in(sin0), .clear_state(clr0),
    .wt_we(we0), .wt_addr(addr0), .wt_data(wd0), .busy(busy0), .done(done0), .spike_out(so0)
  );
  if_tmux_network #(.POT_SIZE(8)) u_d1 (
    .clk(clk), .rst(rst), .start(start1), .spike_in(sin1), .clear_state(clr1),
    .wt_we(we1), .wt_addr(addr1), .wt_data(wd1), .busy(busy1), .done(done1), .spike_out(so1)
  );
  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask
  function automatic int sat(input int x, input int psz);
    int hi;
    hi = (1 << (psz - 1)) - 1;
    return x > hi ? hi : (x < -hi - 1 ? -hi - 1 : x);
  endfunction
  function automatic logic m_step(input int d, input logic [3:0] s);
    logic [3:0] pv, nv;
    int psz, a;
    psz = d ? 8 : 16;
    pv = s;
    for (int l = 0; l < 3; l++) begin
      nv = '0;
      for (int o = 0; o < (l == 2 ? 1 : 4); o++) begin
        a = 0;
        for (int i = 0; i < 4; i++) if (pv[i]) a = sat(a + mw[d][l][o][i], psz);
        if (mr[d][l][o] != 0) mr[d][l][o]--;
        else begin
          mv[d][l][o] = sat(mv[d][l][o] + a, psz);
          if (mv[d][l][o] >= 15) begin
            nv[o] = 1'b1;
            mv[d][l][o] = 0;
            mr[d][l][o] = 5;
          end
        end
      end
      pv = nv;
    end
    return pv[0];
  endfunction
  function automatic void m_clear(input int d);
    for (int l = 0; l < 3; l++)
      for (int o = 0; o < 4; o++) begin
        mv[d][l][o] = 0;
        mr[d][l][o] = 0;
      end
  endfunction
  function automatic void m_reset(input int d);
    m_clear(d);
    for (int l = 0; l < 3; l++)
      for (int o = 0; o < 4; o++)
        for (int i = 0; i < 4; i++) mw[d][l][o][i] = 0;
  endfunction
  always @(negedge clk) if (rst && done0) begin
    chk("sb0_pending", int'(q0.size() > 0), 1);
    if (q0.size() > 0) chk("spike_out0", int'(so0), int'(q0.pop_front()));
    nd0++;
  end
  always @(negedge clk) if (rst && done1) begin
    chk("sb1_pending", int'(q1.size() > 0), 1);
    if (q1.size() > 0) chk("spike_out1", int'(so1), int'(q1.pop_front()));
    nd1++;
  end
  task automatic pulse_start(input int d, input logic [3:0] s);
    if (d == 0) begin start0 = 1; sin0 = s; end
    else begin start1 = 1; sin1 = s; end
    @(negedge clk);
    start0 = 0;
    start1 = 0;
  endtask
  task automatic step(input int d, input logic [3:0] s, input bit lat);
    int n;
    n = 1;
    if (d == 0) q0.push_back(m_step(0, s));
    else q1.push_back(m_step(1, s));
    pulse_start(d, s);
    while (!(d == 0 ? done0 : done1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", int'(d == 0 ? done0 : done1), 1);
    if (lat) chk("latency", n, 46);
    @(negedge clk);
  endtask
  task automatic wr(input int d, input int l, input int o, input int i, input int val, input bit upd);
    logic [5:0] a;
    a = 6'(l * 16 + o * 4 + i);
    if (d == 0) begin we0 = 1; addr0 = a; wd0 = val[7:0]; end
    else begin we1 = 1; addr1 = a; wd1 = val[7:0]; end
    @(negedge clk);
    we0 = 0;
    we1 = 0;
    if (upd) mw[d][l][o][i] = val;
  endtask
  task automatic set_all(input int d, input int val);
    for (int l = 0; l < 3; l++)
      for (int o = 0; o < 4; o++)
        for (int i = 0; i < 4; i++) wr(d, l, o, i, val, 1);
  endtask
  task automatic clr(input int d);
    if (d == 0) clr0 = 1;
    else clr1 = 1;
    @(negedge clk);
    clr0 = 0;
    clr1 = 0;
    m_clear(d);
  endtask
  initial begin
    int n;
    rst = 0;
    {start0, start1, clr0, clr1, we0, we1} = '0;
    {sin0, sin1} = '0;
    {addr0, addr1} = '0;
    {wd0, wd1} = '0;
    repeat (3) @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_done", int'(done0), 0);
    chk("rst_spike", int'(so0), 0);
    chk("rst_busy1", int'(busy1), 0);
    step(0, 4'hF, 1);
    chk("zero_w_spike", int'(so0), 0);
    set_all(0, 8);
    for (int t = 0; t < 7; t++) begin
      step(0, 4'hF, t == 0);
      chk("w8_spike", int'(so0), int'(t == 0 || t == 6));
    end
    n = nd0;
    clr0 = 1; start0 = 1; sin0 = 4'hF;
    @(negedge clk);
    clr0 = 0; start0 = 0;
    m_clear(0);
    repeat (60) @(negedge clk);
    chk("clr_start_dones", nd0 - n, 0);
    chk("clr_start_busy", int'(busy0), 0);
    step(0, 4'hF, 0);
    chk("after_clear_spike", int'(so0), 1);
    clr(0);
    for (int l = 0; l < 3; l++)
      for (int o = 0; o < 4; o++)
        for (int i = 0; i < 4; i++) wr(0, l, o, i, l == 0 ? int'(i == 0) : 16, 1);
    for (int t = 0; t < 35; t++) begin
      step(0, 4'h1, 0);
      chk("sub_thr_spike", int'(so0), int'(t == 14 || t == 34));
    end
    clr(0);
    set_all(0, 8);
    n = nd0;
    q0.push_back(m_step(0, 4'hF));
    pulse_start(0, 4'hF);
    repeat (9) @(negedge clk);
    pulse_start(0, 4'hF);
    repeat (100) @(negedge clk);
    chk("busy_start_dones", nd0 - n, 1);
    clr(0);
    q0.push_back(m_step(0, 4'hF));
    pulse_start(0, 4'hF);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) wr(0, 2, 0, i, -128, 0);
    chk("wr_busy_still_busy", int'(busy0), 1);
    repeat (60) @(negedge clk);
    clr(0);
    step(0, 4'hF, 0);
    chk("wr_busy_ignored", int'(so0), 1);
    pulse_start(0, 4'hF);
    @(negedge clk);
    chk("busy_mid", int'(busy0), 1);
    n = nd0;
    rst = 0;
    #1;
    chk("rst_mid_busy", int'(busy0), 0);
    chk("rst_mid_spike", int'(so0), 0);
    @(negedge clk);
    rst = 1;
    m_reset(0);
    m_reset(1);
    repeat (60) @(negedge clk);
    chk("rst_mid_dones", nd0 - n, 0);
    step(0, 4'hF, 1);
    chk("post_rst_spike", int'(so0), 0);
    set_all(1, 127);
    step(1, 4'hF, 1);
    chk("sat_pos_spike", int'(so1), 1);
    clr(1);
    set_all(1, -128);
    for (int t = 0; t < 4; t++) begin
      step(1, 4'hF, 0);
      chk("sat_neg_spike", int'(so1), 0);
    end
    set_all(1, 127);
    for (int t = 0; t < 2; t++) begin
      step(1, 4'hF, 0);
      chk("sat_recover_spike", int'(so1), int'(t == 1));
    end
    chk("sb0_drained", q0.size(), 0);
    chk("sb1_drained", q1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
